// File: rtl/ad9643_pkg.sv
// Shared types for the AD9643 receive path: captured sample record,
// ramp-checker states and a 16-bit saturating counter helper.
package ad9643_pkg;

  localparam int ADC_W = 14;

  typedef enum logic [1:0] {
    SEARCH,
    CHECK,
    LOCKED
  } rx_state_t;

  typedef struct packed {
    logic [ADC_W-1:0] a;
    logic [ADC_W-1:0] b;
    logic [1:0]       or_bits;
  } sample_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ad9643_sample_fifo.sv
// First-word fall-through synchronous FIFO of captured ADC samples.
// Head entry is presented combinationally whenever the FIFO is non-empty.
module ad9643_sample_fifo
  import ad9643_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_wr_en,
  input  sample_t i_wr_data,
  input  logic    i_rd_en,
  output sample_t o_rd_data,
  output logic    o_full,
  output logic    o_empty
);

  localparam int AW = $clog2(DEPTH);

  sample_t        r_mem [DEPTH];
  logic [AW:0]    r_wr_ptr;
  logic [AW:0]    r_rd_ptr;
  logic           w_push;
  logic           w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // A pop frees the slot the same cycle, so a write to a full FIFO is accepted.
  assign w_pop  = i_rd_en && !o_empty;
  assign w_push = i_wr_en && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/ad9643_rx_capture.sv
// AD9643 DDR receive stage: pairs IDDR words into A/B samples, checks the ramp
// test pattern, and buffers samples onto a valid/ready stream.
// Optional: define AD9643_RX_TWOS_COMP_EN to emit two's-complement data.
module ad9643_rx_capture #(
  parameter int ADC_W      = 14,
  parameter int RAMP_STEP  = 1,
  parameter int LOCK_CNT   = 8,
  parameter int LOSS_CNT   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADC_W-1:0] din_rise,
  input  logic [ADC_W-1:0] din_fall,
  input  logic             or_rise,
  input  logic             or_fall,
  input  logic             din_vld,
  input  logic             chk_en,
  output logic [ADC_W-1:0] m_data_a,
  output logic [ADC_W-1:0] m_data_b,
  output logic [1:0]       m_or,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             locked,
  output logic             lost_sticky,
  output logic [15:0]      err_cnt,
  output logic             ovf_sticky,
  output logic [15:0]      drop_cnt
);

  import ad9643_pkg::*;

  localparam logic [ADC_W-1:0] STEP     = ADC_W'(RAMP_STEP);
  localparam logic [ADC_W-1:0] MSB_MASK = {1'b1, {(ADC_W-1){1'b0}}};
  localparam int               MC_W     = $clog2(LOCK_CNT + 1);
  localparam int               MISS_W   = $clog2(LOSS_CNT + 1);

  // Capture stage
  sample_t r_cap;
  logic    r_cap_vld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cap     <= '0;
      r_cap_vld <= 1'b0;
    end else begin
      r_cap_vld <= din_vld;
      if (din_vld) begin
        r_cap.a       <= din_rise;
        r_cap.b       <= din_fall;
        r_cap.or_bits <= {or_fall, or_rise};
      end
    end
  end

  // Output FIFO
  sample_t          w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;
  logic [ADC_W-1:0] w_out_a;
  logic [ADC_W-1:0] w_out_b;

  ad9643_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (r_cap_vld),
    .i_wr_data (r_cap),
    .i_rd_en   (m_ready),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign w_drop = r_cap_vld && w_full && !(m_ready && !w_empty);

`ifdef AD9643_RX_TWOS_COMP_EN
  assign w_out_a = w_head.a ^ MSB_MASK;
  assign w_out_b = w_head.b ^ MSB_MASK;
`else
  assign w_out_a = w_head.a;
  assign w_out_b = w_head.b;
`endif

  assign m_valid  = !w_empty;
  assign m_data_a = m_valid ? w_out_a : '0;
  assign m_data_b = m_valid ? w_out_b : '0;
  assign m_or     = m_valid ? w_head.or_bits : '0;

  logic        r_ovf;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_ovf      <= 1'b1;
      r_drop_cnt <= sat_inc16(r_drop_cnt);
    end
  end

  assign ovf_sticky = r_ovf;
  assign drop_cnt   = r_drop_cnt;

  // Ramp checker
  rx_state_t         r_state;
  rx_state_t         w_state_nxt;
  logic [ADC_W-1:0]  r_exp;
  logic [MC_W-1:0]   r_mc;
  logic [MISS_W-1:0] r_miss;
  logic              r_locked;
  logic              r_lost;
  logic [15:0]       r_err_cnt;

  logic w_match;
  logic w_lock_done;
  logic w_loss;

  assign w_match     = (r_cap.a == r_exp);
  assign w_lock_done = w_match && (r_mc == MC_W'(LOCK_CNT - 2));
  assign w_loss      = !w_match && (r_miss == MISS_W'(LOSS_CNT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= SEARCH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!chk_en) begin
      w_state_nxt = SEARCH;
    end else if (r_cap_vld) begin
      case (r_state)
        SEARCH:  w_state_nxt = CHECK;
        CHECK:   if (w_lock_done) w_state_nxt = LOCKED;
        LOCKED:  if (w_loss)      w_state_nxt = SEARCH;
        default: w_state_nxt = SEARCH;
      endcase
    end
  end

  logic w_seed;
  logic w_step;
  logic w_mc_inc;
  logic w_mc_clr;
  logic w_miss_inc;
  logic w_miss_clr;
  logic w_err_evt;
  logic w_lost_set;

  // In LOCKED the expectation always advances, so one bad word costs one error.
  always_comb begin
    w_seed     = 1'b0;
    w_step     = 1'b0;
    w_mc_inc   = 1'b0;
    w_mc_clr   = 1'b0;
    w_miss_inc = 1'b0;
    w_miss_clr = 1'b0;
    w_err_evt  = 1'b0;
    w_lost_set = 1'b0;
    if (chk_en && r_cap_vld) begin
      case (r_state)
        SEARCH: begin
          w_seed     = 1'b1;
          w_mc_clr   = 1'b1;
          w_miss_clr = 1'b1;
        end
        CHECK: begin
          if (w_match) begin
            w_step   = 1'b1;
            w_mc_inc = 1'b1;
          end else begin
            w_seed   = 1'b1;
            w_mc_clr = 1'b1;
          end
        end
        LOCKED: begin
          w_step = 1'b1;
          if (w_match) begin
            w_miss_clr = 1'b1;
          end else begin
            w_err_evt = 1'b1;
            if (w_loss) begin
              w_miss_clr = 1'b1;
              w_lost_set = 1'b1;
            end else begin
              w_miss_inc = 1'b1;
            end
          end
        end
        default: begin
          w_seed = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_exp     <= '0;
      r_mc      <= '0;
      r_miss    <= '0;
      r_locked  <= 1'b0;
      r_lost    <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_locked <= (w_state_nxt == LOCKED);
      if (!chk_en) begin
        r_mc   <= '0;
        r_miss <= '0;
        r_lost <= 1'b0;
      end else begin
        if (w_seed)      r_exp <= r_cap.a + STEP;
        else if (w_step) r_exp <= r_exp + STEP;
        if (w_mc_clr)      r_mc <= '0;
        else if (w_mc_inc) r_mc <= r_mc + MC_W'(1);
        if (w_miss_clr)      r_miss <= '0;
        else if (w_miss_inc) r_miss <= r_miss + MISS_W'(1);
        if (w_lost_set) r_lost <= 1'b1;
      end
      if (w_err_evt) r_err_cnt <= sat_inc16(r_err_cnt);
    end
  end

  assign locked      = r_locked;
  assign lost_sticky = r_lost;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_ad9643_rx_capture.sv
// Self-checking bench for ad9643_rx_capture: directed table, ramp/lock/overflow
// sequences and a randomized phase against a queue-based reference model.
module tb_ad9643_rx_capture;

  localparam int W     = 14;
  localparam int DEPTH = 4;
  localparam int LOCKN = 8;
  localparam int LOSSN = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din_rise = '0;
  logic [W-1:0] din_fall = '0;
  logic         or_rise = 1'b0;
  logic         or_fall = 1'b0;
  logic         din_vld = 1'b0;
  logic         chk_en = 1'b0;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_data_a;
  logic [W-1:0] m_data_b;
  logic [1:0]   m_or;
  logic         m_valid;
  logic         locked;
  logic         lost_sticky;
  logic [15:0]  err_cnt;
  logic         ovf_sticky;
  logic [15:0]  drop_cnt;

  always #5 clk = ~clk;

  ad9643_rx_capture #(
    .ADC_W      (W),
    .RAMP_STEP  (1),
    .LOCK_CNT   (LOCKN),
    .LOSS_CNT   (LOSSN),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din_rise    (din_rise),
    .din_fall    (din_fall),
    .or_rise     (or_rise),
    .or_fall     (or_fall),
    .din_vld     (din_vld),
    .chk_en      (chk_en),
    .m_data_a    (m_data_a),
    .m_data_b    (m_data_b),
    .m_or        (m_or),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .locked      (locked),
    .lost_sticky (lost_sticky),
    .err_cnt     (err_cnt),
    .ovf_sticky  (ovf_sticky),
    .drop_cnt    (drop_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, expv);
    end
  endtask

  function automatic logic [W-1:0] conv(input logic [W-1:0] x);
`ifdef AD9643_RX_TWOS_COMP_EN
    return x ^ 14'h2000;
`else
    return x;
`endif
  endfunction

  // Reference model: sample queue plus ramp tracker flags
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   orv;
  } smp_t;

  smp_t         q[$];
  smp_t         pend;
  bit           pend_v;
  bit           seeded, lk, lost, ovf;
  int           run, miss, err, drop;
  logic [W-1:0] expv;

  function automatic void model_reset();
    q.delete();
    pend = '0; pend_v = 0;
    seeded = 0; lk = 0; lost = 0; ovf = 0;
    run = 0; miss = 0; err = 0; drop = 0;
    expv = '0;
  endfunction

  function automatic void ramp_check(input logic [W-1:0] a);
    if (!seeded) begin
      seeded = 1; run = 0; expv = a + 14'd1;
    end else if (!lk) begin
      if (a == expv) begin
        run++; expv = expv + 14'd1;
        if (run == LOCKN - 1) lk = 1;
      end else begin
        run = 0; expv = a + 14'd1;
      end
    end else begin
      if (a != expv) begin
        if (err < 65535) err++;
        miss++;
        if (miss == LOSSN) begin
          lk = 0; seeded = 0; lost = 1; miss = 0;
        end
      end else begin
        miss = 0;
      end
      expv = expv + 14'd1;
    end
  endfunction

  function automatic void model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_ready && q.size() > 0) void'(q.pop_front());
    if (pend_v) begin
      if (q.size() < DEPTH) q.push_back(pend);
      else begin
        ovf = 1;
        if (drop < 65535) drop++;
      end
    end
    if (!chk_en) begin
      seeded = 0; lk = 0; run = 0; miss = 0; lost = 0;
    end else if (pend_v) begin
      ramp_check(pend.a);
    end
    pend_v = din_vld;
    if (din_vld) pend = '{a: din_rise, b: din_fall, orv: {or_fall, or_rise}};
  endfunction

  task automatic compare_model();
    check("m_valid", 32'(m_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check("m_data_a", 32'(m_data_a), 32'(conv(q[0].a)));
      check("m_data_b", 32'(m_data_b), 32'(conv(q[0].b)));
      check("m_or", 32'(m_or), 32'(q[0].orv));
    end
    check("locked", 32'(locked), 32'(lk));
    check("lost_sticky", 32'(lost_sticky), 32'(lost));
    check("err_cnt", 32'(err_cnt), err);
    check("ovf_sticky", 32'(ovf_sticky), 32'(ovf));
    check("drop_cnt", 32'(drop_cnt), drop);
  endtask

  task automatic step(input bit vld, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] orv, input bit ce, input bit rdy);
    din_vld  = vld;
    din_rise = a;
    din_fall = b;
    or_rise  = orv[0];
    or_fall  = orv[1];
    chk_en   = ce;
    m_ready  = rdy;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    compare_model();
  endtask

  task automatic ramp(input logic [W-1:0] v);
    step(1'b1, v, W'($urandom), 2'($urandom), 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, '0, '0, 2'b00, 1'b0, 1'b0);
    step(1'b0, '0, '0, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit           vld;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   orv;
    bit           rdy;
    bit           ev;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic [1:0]   eor;
  } vec_t;

  vec_t         tbl[8];
  logic [W-1:0] v;
  int           burst;

  initial begin
    tbl[0] = '{1'b1, 14'h0011, 14'h0022, 2'b01, 1'b0, 1'b0, 14'h0000, 14'h0000, 2'b00};
    tbl[1] = '{1'b1, 14'h0033, 14'h0044, 2'b10, 1'b0, 1'b1, 14'h0011, 14'h0022, 2'b01};
    tbl[2] = '{1'b0, 14'h0000, 14'h0000, 2'b00, 1'b0, 1'b1, 14'h0011, 14'h0022, 2'b01};
    tbl[3] = '{1'b0, 14'h0000, 14'h0000, 2'b00, 1'b1, 1'b1, 14'h0033, 14'h0044, 2'b10};
    tbl[4] = '{1'b0, 14'h0000, 14'h0000, 2'b00, 1'b1, 1'b0, 14'h0000, 14'h0000, 2'b00};
    tbl[5] = '{1'b1, 14'h2000, 14'h0000, 2'b11, 1'b1, 1'b0, 14'h0000, 14'h0000, 2'b00};
    tbl[6] = '{1'b0, 14'h0000, 14'h0000, 2'b00, 1'b1, 1'b1, 14'h2000, 14'h0000, 2'b11};
    tbl[7] = '{1'b0, 14'h0000, 14'h0000, 2'b00, 1'b1, 1'b0, 14'h0000, 14'h0000, 2'b00};

    model_reset();
    do_reset();
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data_a", 32'(m_data_a), 32'd0);
    check("rst_m_data_b", 32'(m_data_b), 32'd0);
    check("rst_m_or", 32'(m_or), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);

    // Latency, hold while not ready, ordering, data conversion
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].vld, tbl[i].a, tbl[i].b, tbl[i].orv, 1'b0, tbl[i].rdy);
      check("tbl_valid", 32'(m_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        check("tbl_data_a", 32'(m_data_a), 32'(conv(tbl[i].ea)));
        check("tbl_data_b", 32'(m_data_b), 32'(conv(tbl[i].eb)));
        check("tbl_or", 32'(m_or), 32'(tbl[i].eor));
      end
    end

    // Lock after 8 ramp captures
    for (int i = 0; i < 8; i++) ramp(W'(i));
    check("no_lock_after_7", 32'(locked), 32'd0);
    ramp(14'd8);
    check("lock_after_8", 32'(locked), 32'd1);
    check("lock_err0", 32'(err_cnt), 32'd0);
    check("ramp_latency", 32'(m_data_a), 32'(conv(14'd7)));

    // Single glitch at 0x0100
    v = 14'd9;
    while (v != 14'h0100) begin ramp(v); v = v + 14'd1; end
    ramp(14'h0ABC); v = v + 14'd1;
    for (int i = 0; i < 4; i++) begin ramp(v); v = v + 14'd1; end
    check("glitch_err", 32'(err_cnt), 32'd1);
    check("glitch_locked", 32'(locked), 32'd1);
    check("glitch_lost", 32'(lost_sticky), 32'd0);

    // Four corrupt words drop lock, then relock on clean ramp
    for (int i = 0; i < 4; i++) begin ramp(v ^ 14'h1555); v = v + 14'd1; end
    check("still_locked_3bad", 32'(locked), 32'd1);
    ramp(v); v = v + 14'd1;
    check("loss_locked", 32'(locked), 32'd0);
    check("loss_sticky", 32'(lost_sticky), 32'd1);
    check("loss_err", 32'(err_cnt), 32'd5);
    for (int i = 0; i < 7; i++) begin ramp(v); v = v + 14'd1; end
    check("relock_not_yet", 32'(locked), 32'd0);
    ramp(v); v = v + 14'd1;
    check("relock", 32'(locked), 32'd1);
    check("relock_lost_kept", 32'(lost_sticky), 32'd1);

    // chk_en low clears lost_sticky, holds err_cnt
    step(1'b0, '0, '0, 2'b00, 1'b0, 1'b1);
    check("chk_off_lost", 32'(lost_sticky), 32'd0);
    check("chk_off_locked", 32'(locked), 32'd0);
    check("chk_off_err", 32'(err_cnt), 32'd5);

    // Wrap-around ramp
    v = 14'h3FF0;
    for (int i = 0; i < 21; i++) begin ramp(v); v = v + 14'd1; end
    check("wrap_locked", 32'(locked), 32'd1);
    check("wrap_err", 32'(err_cnt), 32'd5);

    // Overflow: 6 samples into a stalled 4-deep FIFO
    step(1'b0, '0, '0, 2'b00, 1'b1, 1'b1);
    step(1'b0, '0, '0, 2'b00, 1'b1, 1'b1);
    for (int i = 1; i <= 6; i++) step(1'b1, W'(14'h0100 + i), W'(i), 2'b00, 1'b1, 1'b0);
    step(1'b0, '0, '0, 2'b00, 1'b1, 1'b0);
    check("ovf_drop", 32'(drop_cnt), 32'd2);
    check("ovf_sticky", 32'(ovf_sticky), 32'd1);
    check("ovf_head", 32'(m_data_a), 32'(conv(14'h0101)));
    for (int j = 1; j <= 4; j++) begin
      step(1'b0, '0, '0, 2'b00, 1'b1, 1'b1);
      if (j < 4) check("drain_order", 32'(m_data_a), 32'(conv(W'(14'h0101 + j))));
      else       check("drain_empty", 32'(m_valid), 32'd0);
    end

    // Reset mid-operation with data queued
    for (int i = 0; i < 3; i++) step(1'b1, W'($urandom), W'($urandom), 2'b01, 1'b1, 1'b0);
    do_reset();
    check("midrst_valid", 32'(m_valid), 32'd0);
    check("midrst_ovf", 32'(ovf_sticky), 32'd0);
    check("midrst_drop", 32'(drop_cnt), 32'd0);

    // Randomized ramp with corruption, stalls, checker toggles and resets
    v = 14'h3F00;
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      bit           vld, ce, rdy;
      logic [W-1:0] a;
      if ($urandom_range(0, 999) < 3) begin
        do_reset();
      end else begin
        vld = ($urandom_range(0, 3) != 0);
        ce  = ($urandom_range(0, 199) != 0);
        rdy = ($urandom_range(0, 2) != 0);
        if (burst == 0 && $urandom_range(0, 149) == 0) burst = $urandom_range(3, 5);
        a = v;
        if (vld) begin
          if (burst > 0) begin a = v ^ 14'h0F0F; burst--; end
          else if ($urandom_range(0, 29) == 0) a = W'($urandom);
          v = v + 14'd1;
        end
        step(vld, a, W'($urandom), 2'($urandom), ce, rdy);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
